twos_to_signmag_serial: RTL and testbench

Bit-serial decoder converting a W-bit two's-complement result from the signed calculator datapath back into sign-magnitude form for display/readout. It is the inverse of the conditional two's-complement encoder in the calculator front end: a captured word is processed LSB-first, one bit per clock, using the copy-until-first-one / invert-thereafter rule. Valid/ready handshakes on both sides allow it to sit between the adder/subtractor result register and the output formatter.

---
 rtl/twos_to_signmag_serial.sv | 84 ++++++++
 tb/tb_twos_to_signmag_serial.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/twos_to_signmag_serial.sv
// Bit-serial two's-complement to sign-magnitude decoder.
// One bit per clock, LSB first: bits are copied up to and including the first 1, then inverted if the word is negative.
module twos_to_signmag_serial #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_sign,
    output logic [W-1:0] out_mag,
    output logic         busy
);

    localparam int CNT_W = $clog2(W);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t              state;
    logic signed [W-1:0] shift_reg;
    logic                sign_r;
    logic                seen_one;
    logic [CNT_W-1:0]    bit_cnt;

    function automatic logic decode_bit(input logic b, input logic neg, input logic seen);
        return b ^ (neg & seen);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            out_sign  <= 1'b0;
            out_mag   <= '0;
            shift_reg <= '0;
            sign_r    <= 1'b0;
            seen_one  <= 1'b0;
            bit_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        shift_reg <= in_data;
                        sign_r    <= in_data[W-1];
                        out_sign  <= in_data[W-1];
                        out_mag   <= '0;
                        seen_one  <= 1'b0;
                        bit_cnt   <= '0;
                        in_ready  <= 1'b0;
                        busy      <= 1'b1;
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    // Decoded bits enter at the MSB so the first bit lands at bit 0 after W shifts.
                    out_mag   <= {decode_bit(shift_reg[0], sign_r, seen_one), out_mag[W-1:1]};
                    seen_one  <= seen_one | shift_reg[0];
                    shift_reg <= shift_reg >> 1;
                    if (bit_cnt == CNT_W'(W - 1)) begin
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_twos_to_signmag_serial.sv
// Scoreboard bench for twos_to_signmag_serial: the driver queues expected results, the monitor checks every output.
module tb_twos_to_signmag_serial;

    localparam int W = 10;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic         out_sign;
    logic [W-1:0] out_mag;
    logic         busy;

    typedef struct {
        logic         s;
        logic [W-1:0] m;
        int           t;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    bit   sweep_done;

    twos_to_signmag_serial #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sign  (out_sign),
        .out_mag   (out_mag),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic timeout(input string name);
        tests++;
        fails++;
        $display("FAIL %s: wait bound expired at cycle %0d", name, cyc);
    endtask

    function automatic logic [W-1:0] ref_mag(input logic [W-1:0] d);
        logic [W-1:0] n;
        n = -d;
        return d[W-1] ? n : d;
    endfunction

    task automatic send(input logic [W-1:0] d, input logic s, input logic [W-1:0] m);
        int n;
        exp_t e;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            timeout("accept_wait");
            return;
        end
        in_valid = 1'b1;
        in_data  = d;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = W'($urandom);
        e.s = s;
        e.m = m;
        e.t = cyc;
        q.push_back(e);
        chk("ready_low_after_accept", 32'(in_ready), 32'd0);
    endtask

    task automatic flush();
        int n;
        n = 0;
        while ((q.size() != 0 || out_valid) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0 || out_valid) timeout("flush");
    endtask

    // Monitor: pop on each new result, then require it to hold while out_valid stays high.
    initial begin : monitor
        logic         prev_v;
        logic         h_s;
        logic [W-1:0] h_m;
        exp_t         e;
        prev_v = 1'b0;
        h_s    = 1'b0;
        h_m    = '0;
        forever begin
            @(negedge clk);
            if (out_valid && !prev_v) begin
                if (q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_output: sign %0d mag %0h with empty scoreboard", out_sign, out_mag);
                end else begin
                    e = q.pop_front();
                    chk("out_sign", 32'(out_sign), 32'(e.s));
                    chk("out_mag", 32'(out_mag), 32'(e.m));
                    chk("latency", 32'(cyc - e.t), 32'(W));
                end
                h_s = out_sign;
                h_m = out_mag;
            end else if (out_valid) begin
                chk("hold_sign", 32'(out_sign), 32'(h_s));
                chk("hold_mag", 32'(out_mag), 32'(h_m));
            end
            prev_v = out_valid;
        end
    end

    initial begin : stim
        int n;
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_data    = '0;
        out_ready  = 1'b1;
        sweep_done = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_out_mag", 32'(out_mag), 32'd0);
        chk("rst_out_sign", 32'(out_sign), 32'd0);
        rst = 1'b0;

        // Reset in the middle of a conversion discards it.
        in_valid = 1'b1;
        in_data  = 10'h3F6;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("busy_in_shift", 32'(busy), 32'd1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_out_mag", 32'(out_mag), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        send(10'h005, 1'b0, 10'h005);
        flush();

        // Directed values and boundaries.
        send(10'h3F6, 1'b1, 10'h00A);
        send(10'h000, 1'b0, 10'h000);
        send(10'h1FF, 1'b0, 10'h1FF);
        send(10'h3FF, 1'b1, 10'h001);
        send(10'h200, 1'b1, 10'h200);
        send(10'h2AB, 1'b1, 10'h155);
        send(10'h155, 1'b0, 10'h155);
        send(10'h001, 1'b0, 10'h001);
        flush();

        // Back-pressure holds the result in DONE.
        out_ready = 1'b0;
        send(10'h381, 1'b1, 10'h07F);
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) timeout("bp_valid_wait");
        repeat (20) begin
            @(negedge clk);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_in_ready", 32'(in_ready), 32'd1);
        chk("bp_release_out_valid", 32'(out_valid), 32'd0);

        // Input activity while busy is ignored.
        send(10'h2C5, 1'b1, 10'h13B);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = W'($urandom);
            chk("busy_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        flush();

        // Random sweep with random out_ready stalls.
        fork
            begin
                logic [W-1:0] d;
                for (int i = 0; i < 1000; i++) begin
                    d = W'($urandom_range(0, 1023));
                    send(d, d[W-1], ref_mag(d));
                end
                sweep_done = 1'b1;
            end
            begin
                while (!sweep_done) begin
                    @(negedge clk);
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready = 1'b1;
        flush();
        repeat (3 * W) @(negedge clk);
        chk("final_queue_empty", 32'(q.size()), 32'd0);
        chk("final_idle", 32'(in_ready), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
